// File: rtl/cheshire_rule_decoder.sv
// Runtime-programmable address-rule decoder.
// A 2-stage lookup pipeline maps an address to a target port using the rule table.
// A background scan FSM flags any different-port overlap in the table.
module cheshire_rule_decoder #(
    parameter int unsigned NumRules    = 16,
    parameter int unsigned NumPorts    = 8,
    parameter int unsigned AddrWidth   = 48,
    parameter bit          EnDefault   = 1'b1,
    parameter int unsigned DefaultPort = 0,
    parameter int unsigned IdxW        = $clog2(NumPorts),
    parameter int unsigned RuleW       = $clog2(NumRules)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    input  logic [RuleW-1:0]     cfg_idx_i,
    input  logic                 cfg_en_i,
    input  logic [IdxW-1:0]      cfg_port_i,
    input  logic [AddrWidth-1:0] cfg_start_i,
    input  logic [AddrWidth-1:0] cfg_end_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [IdxW-1:0]      rsp_port_o,
    output logic [RuleW-1:0]     rsp_rule_o,
    output logic                 rsp_hit_o,
    output logic                 rsp_err_o,
    output logic                 scan_busy_o,
    output logic                 overlap_o
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t state, state_next;

    logic [NumRules-1:0]  rule_en;
    logic [AddrWidth-1:0] rule_start [NumRules];
    logic [AddrWidth-1:0] rule_end   [NumRules];
    logic [IdxW-1:0]      rule_port  [NumRules];

    logic cfg_fire;

    assign cfg_ready_o = (state == IDLE);
    assign scan_busy_o = (state == SCAN);
    assign cfg_fire    = cfg_valid_i && cfg_ready_o;

    // Rule table: cleared on reset, one entry written per accepted config beat
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rule_en <= '0;
            for (int unsigned r = 0; r < NumRules; r++) begin
                rule_start[r] <= '0;
                rule_end[r]   <= '0;
                rule_port[r]  <= '0;
            end
        end else if (cfg_fire) begin
            rule_en[cfg_idx_i]    <= cfg_en_i;
            rule_start[cfg_idx_i] <= cfg_start_i;
            rule_end[cfg_idx_i]   <= cfg_end_i;
            rule_port[cfg_idx_i]  <= cfg_port_i;
        end
    end

    // ------------------------------------------------------------------
    // Lookup pipeline
    // ------------------------------------------------------------------
    logic [NumRules-1:0] match;
    logic [IdxW-1:0]     match_port;
    logic                s1_valid;
    logic [NumRules-1:0] s1_match;
    logic [IdxW-1:0]     s1_port;
    logic                s1_adv, s2_adv;
    logic                enc_hit;
    logic [RuleW-1:0]    enc_rule;

    assign s2_adv      = !rsp_valid_o || rsp_ready_i;
    assign s1_adv      = !s1_valid || s2_adv;
    assign req_ready_o = s1_adv;

    // Match vector of the incoming address; the winning rule's port is picked here as well
    // so that a config write landing while the lookup sits in S1 cannot change its port.
    always_comb begin
        match      = '0;
        match_port = '0;
        for (int unsigned r = 0; r < NumRules; r++) begin
            match[r] = rule_en[r] && (req_addr_i >= rule_start[r]) && (req_addr_i < rule_end[r]);
        end
        for (int unsigned r = NumRules; r > 0; r--) begin
            if (match[r-1]) match_port = rule_port[r-1];
        end
    end

    // S1: snapshot of match vector and winning port
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            s1_match <= '0;
            s1_port  <= '0;
        end else if (s1_adv) begin
            s1_valid <= req_valid_i;
            if (req_valid_i) begin
                s1_match <= match;
                s1_port  <= match_port;
            end
        end
    end

    // Priority encoder: lowest set index of the S1 match vector
    always_comb begin
        enc_hit  = 1'b0;
        enc_rule = '0;
        for (int unsigned r = 0; r < NumRules; r++) begin
            if (s1_match[r] && !enc_hit) begin
                enc_hit  = 1'b1;
                enc_rule = RuleW'(r);
            end
        end
    end

    // S2: response registers, held while the consumer stalls
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rsp_valid_o <= 1'b0;
            rsp_port_o  <= '0;
            rsp_rule_o  <= '0;
            rsp_hit_o   <= 1'b0;
            rsp_err_o   <= 1'b0;
        end else if (s2_adv) begin
            rsp_valid_o <= s1_valid;
            if (s1_valid) begin
                rsp_hit_o  <= enc_hit;
                rsp_rule_o <= enc_rule;
                rsp_err_o  <= !enc_hit && !EnDefault;
                if (enc_hit)        rsp_port_o <= s1_port;
                else if (EnDefault) rsp_port_o <= IdxW'(DefaultPort);
                else                rsp_port_o <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Overlap scan
    // ------------------------------------------------------------------
    logic [RuleW-1:0] scan_i, scan_j;
    logic             acc;
    logic             conflict;
    logic             last_pair;

    // Pair (i,j) conflicts when both are live, target different ports and their ranges intersect
    always_comb begin
        conflict = rule_en[scan_i] && rule_en[scan_j]
                && (rule_start[scan_i] < rule_end[scan_i])
                && (rule_start[scan_j] < rule_end[scan_j])
                && (rule_port[scan_i] != rule_port[scan_j])
                && (rule_start[scan_i] < rule_end[scan_j])
                && (rule_start[scan_j] < rule_end[scan_i]);
    end

    assign last_pair = (scan_i == RuleW'(NumRules - 2)) && (scan_j == RuleW'(NumRules - 1));

    // Scan FSM state register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_next;
    end

    // Scan FSM next-state: any accepted write triggers a full rescan
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cfg_fire) state_next = SCAN;
            SCAN:    if (last_pair) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Pair counters, accumulator and published overlap flag
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            scan_i    <= '0;
            scan_j    <= '0;
            acc       <= 1'b0;
            overlap_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_fire) begin
                        scan_i <= '0;
                        scan_j <= RuleW'(1);
                        acc    <= 1'b0;
                    end
                end
                SCAN: begin
                    acc <= acc | conflict;
                    if (last_pair) begin
                        overlap_o <= acc | conflict;
                    end else if (scan_j == RuleW'(NumRules - 1)) begin
                        scan_i <= scan_i + RuleW'(1);
                        scan_j <= scan_i + RuleW'(2);
                    end else begin
                        scan_j <= scan_j + RuleW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cheshire_rule_decoder.sv
// Self-checking bench for cheshire_rule_decoder.
// Two instances share stimulus: one with a default port (3), one returning errors.
module tb_cheshire_rule_decoder;

    localparam int unsigned NR  = 16;
    localparam int unsigned NP  = 8;
    localparam int unsigned AW  = 48;
    localparam int unsigned IW  = 3;
    localparam int unsigned RW  = 4;
    localparam int unsigned DEF = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          cfg_valid, cfg_en;
    logic [RW-1:0] cfg_idx;
    logic [IW-1:0] cfg_port;
    logic [AW-1:0] cfg_start, cfg_end;
    logic          req_valid, rsp_ready;
    logic [AW-1:0] req_addr;

    logic          cfg_ready_a, req_ready_a, rsp_valid_a, rsp_hit_a, rsp_err_a, scan_busy_a, overlap_a;
    logic [IW-1:0] rsp_port_a;
    logic [RW-1:0] rsp_rule_a;
    logic          cfg_ready_b, req_ready_b, rsp_valid_b, rsp_hit_b, rsp_err_b, scan_busy_b, overlap_b;
    logic [IW-1:0] rsp_port_b;
    logic [RW-1:0] rsp_rule_b;

    cheshire_rule_decoder #(
        .NumRules(NR), .NumPorts(NP), .AddrWidth(AW), .EnDefault(1'b1), .DefaultPort(DEF)
    ) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready_a), .cfg_idx_i(cfg_idx), .cfg_en_i(cfg_en),
        .cfg_port_i(cfg_port), .cfg_start_i(cfg_start), .cfg_end_i(cfg_end),
        .req_valid_i(req_valid), .req_ready_o(req_ready_a), .req_addr_i(req_addr),
        .rsp_valid_o(rsp_valid_a), .rsp_ready_i(rsp_ready), .rsp_port_o(rsp_port_a),
        .rsp_rule_o(rsp_rule_a), .rsp_hit_o(rsp_hit_a), .rsp_err_o(rsp_err_a),
        .scan_busy_o(scan_busy_a), .overlap_o(overlap_a)
    );

    cheshire_rule_decoder #(
        .NumRules(NR), .NumPorts(NP), .AddrWidth(AW), .EnDefault(1'b0), .DefaultPort(5)
    ) u_dut_nd (
        .clk_i(clk), .rst_ni(rst_n),
        .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready_b), .cfg_idx_i(cfg_idx), .cfg_en_i(cfg_en),
        .cfg_port_i(cfg_port), .cfg_start_i(cfg_start), .cfg_end_i(cfg_end),
        .req_valid_i(req_valid), .req_ready_o(req_ready_b), .req_addr_i(req_addr),
        .rsp_valid_o(rsp_valid_b), .rsp_ready_i(rsp_ready), .rsp_port_o(rsp_port_b),
        .rsp_rule_o(rsp_rule_b), .rsp_hit_o(rsp_hit_b), .rsp_err_o(rsp_err_b),
        .scan_busy_o(scan_busy_b), .overlap_o(overlap_b)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic          m_en    [NR];
    logic [AW-1:0] m_start [NR];
    logic [AW-1:0] m_end   [NR];
    logic [IW-1:0] m_port  [NR];

    typedef struct {
        logic [IW-1:0] port_a;
        logic [IW-1:0] port_b;
        logic [RW-1:0] rule;
        logic          hit;
        logic          err_b;
    } exp_t;

    exp_t          sb[$];
    logic [IW-1:0] log_port[$];
    logic          log_hit[$];
    int            n_rsp = 0;

    // First enabled rule whose half-open range holds the address wins
    function automatic exp_t ref_lookup(input logic [AW-1:0] a);
        exp_t e;
        e.hit = 1'b0; e.rule = '0; e.port_a = IW'(DEF); e.port_b = '0; e.err_b = 1'b1;
        for (int r = 0; r < NR; r++) begin
            if (m_en[r] && a >= m_start[r] && a < m_end[r]) begin
                e.hit = 1'b1; e.rule = RW'(r); e.port_a = m_port[r]; e.port_b = m_port[r]; e.err_b = 1'b0;
                return e;
            end
        end
        return e;
    endfunction

    function automatic logic ref_overlap();
        for (int i = 0; i < NR; i++)
            for (int j = i + 1; j < NR; j++)
                if (m_en[i] && m_en[j] && m_start[i] < m_end[i] && m_start[j] < m_end[j]
                    && m_port[i] != m_port[j] && m_start[i] < m_end[j] && m_start[j] < m_end[i])
                    return 1'b1;
        return 1'b0;
    endfunction

    // Monitor on the falling edge: sees exactly what the next rising edge will act on
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            for (int r = 0; r < NR; r++) begin
                m_en[r] = 1'b0; m_start[r] = '0; m_end[r] = '0; m_port[r] = '0;
            end
        end else begin
            // Only two lookups fit in flight; the request side stalls only with both held
            check("req_ready", req_ready_a, !(sb.size() == 2 && !rsp_ready));
            check("req_ready_nd", req_ready_b, !(sb.size() == 2 && !rsp_ready));
            if (rsp_valid_a && rsp_ready) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_port", rsp_port_a, e.port_a);
                    check("rsp_rule", rsp_rule_a, e.rule);
                    check("rsp_hit", rsp_hit_a, e.hit);
                    check("rsp_err", rsp_err_a, 0);
                    check("rsp_valid_nd", rsp_valid_b, 1);
                    check("rsp_port_nd", rsp_port_b, e.port_b);
                    check("rsp_rule_nd", rsp_rule_b, e.rule);
                    check("rsp_err_nd", rsp_err_b, e.err_b);
                    log_port.push_back(rsp_port_a);
                    log_hit.push_back(rsp_hit_a);
                    n_rsp++;
                end
            end
            if (req_valid && req_ready_a) sb.push_back(ref_lookup(req_addr));
            if (cfg_valid && cfg_ready_a) begin
                m_en[cfg_idx] = cfg_en; m_start[cfg_idx] = cfg_start;
                m_end[cfg_idx] = cfg_end; m_port[cfg_idx] = cfg_port;
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [RW-1:0] idx, input logic en, input logic [IW-1:0] port,
                            input logic [AW-1:0] s, input logic [AW-1:0] e, output int stalls);
        logic ok;
        cfg_valid = 1'b1; cfg_idx = idx; cfg_en = en; cfg_port = port; cfg_start = s; cfg_end = e;
        stalls = 0;
        forever begin
            @(negedge clk); ok = cfg_ready_a;
            tick();
            if (ok) break;
            stalls++;
            if (stalls > 1000) begin check("cfg_accept_timeout", 0, 1); break; end
        end
        cfg_valid = 1'b0;
    endtask

    // Leaves req_valid asserted so callers can stream back-to-back
    task automatic send_req(input logic [AW-1:0] a);
        logic ok;
        int n;
        req_valid = 1'b1; req_addr = a; n = 0;
        forever begin
            @(negedge clk); ok = req_ready_a;
            tick();
            if (ok) break;
            n++;
            if (n > 200) begin check("req_accept_timeout", 0, 1); break; end
        end
    endtask

    task automatic wait_scan(output int n);
        n = 0;
        while (scan_busy_a && n < 1000) begin tick(); n++; end
    endtask

    task automatic wait_rsp(output logic got);
        int n;
        n = 0;
        while (!rsp_valid_a && n < 50) begin tick(); n++; end
        got = rsp_valid_a;
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic [IW-1:0] port;
        logic [RW-1:0] rule;
        logic          hit;
    } vec_t;

    vec_t vt[6];
    logic done_b;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   st, n, base;
        logic got;
        logic [AW-1:0] stream_addr[8];
        logic [63:0]   tmp64;

        vt[0] = '{48'h0000_8000_0800, 3'd5, 4'd2, 1'b1};
        vt[1] = '{48'h0000_FFFF_FFFF, 3'd5, 4'd2, 1'b1};
        vt[2] = '{48'h0001_0000_0000, 3'd3, 4'd0, 1'b0};
        vt[3] = '{48'h0000_7FFF_FFFF, 3'd3, 4'd0, 1'b0};
        vt[4] = '{48'h0000_8000_0000, 3'd5, 4'd2, 1'b1};
        vt[5] = '{48'h0000_8000_1000, 3'd5, 4'd2, 1'b1};

        stream_addr[0] = 48'h0000_8000_0800; stream_addr[1] = 48'h0000_0000_1000;
        stream_addr[2] = 48'h0000_0000_2000; stream_addr[3] = 48'h0000_FFFF_FFFF;
        stream_addr[4] = 48'h0001_0000_0000; stream_addr[5] = 48'h0000_8000_0000;
        stream_addr[6] = 48'h0000_7FFF_FFFF; stream_addr[7] = 48'h0000_9000_0000;

        rst_n = 1'b0; cfg_valid = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_port = '0;
        cfg_start = '0; cfg_end = '0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
        done_b = 1'b0;
        tick(); tick();
        rst_n = 1'b1;

        // Reset state
        check("rst_cfg_ready", cfg_ready_a, 1);
        check("rst_req_ready", req_ready_a, 1);
        check("rst_rsp_valid", rsp_valid_a, 0);
        check("rst_rsp_port", rsp_port_a, 0);
        check("rst_rsp_rule", rsp_rule_a, 0);
        check("rst_rsp_hit", rsp_hit_a, 0);
        check("rst_rsp_err", rsp_err_a, 0);
        check("rst_scan_busy", scan_busy_a, 0);
        check("rst_overlap", overlap_a, 0);
        check("rst_rsp_err_nd", rsp_err_b, 0);

        // Empty table: default port on one instance, error on the other; response two edges after request
        send_req(48'h1000); req_valid = 1'b0;
        check("lat_edge1_valid", rsp_valid_a, 0);
        tick();
        check("lat_edge2_valid", rsp_valid_a, 1);
        check("dflt_port", rsp_port_a, 3);
        check("dflt_hit", rsp_hit_a, 0);
        check("dflt_err", rsp_err_a, 0);
        check("dflt_rule", rsp_rule_a, 0);
        check("nodflt_err", rsp_err_b, 1);
        check("nodflt_port", rsp_port_b, 0);
        tick();

        // Conflicting rules 2 (port 5) and 6 (port 1)
        do_write(4'd2, 1'b1, 3'd5, 48'h0000_8000_0000, 48'h0001_0000_0000, st);
        check("scan_busy_after_write", scan_busy_a, 1);
        check("cfg_ready_after_write", cfg_ready_a, 0);
        do_write(4'd6, 1'b1, 3'd1, 48'h0000_8000_0000, 48'h0000_8000_1000, st);
        check("write_stall_cycles", st, 120);
        check("overlap_hold_during_scan", overlap_a, 0);
        wait_scan(n);
        check("scan_cycles", n, 120);
        check("overlap_set", overlap_a, 1);
        check("cfg_ready_after_scan", cfg_ready_a, 1);

        // Table-driven lookups against the two-rule setup
        for (int i = 0; i < 6; i++) begin
            send_req(vt[i].addr); req_valid = 1'b0;
            wait_rsp(got);
            check("vec_rsp_valid", got, 1);
            check("vec_port", rsp_port_a, vt[i].port);
            check("vec_rule", rsp_rule_a, vt[i].rule);
            check("vec_hit", rsp_hit_a, vt[i].hit);
            check("vec_port_nd", rsp_port_b, vt[i].hit ? vt[i].port : 3'd0);
            check("vec_err_nd", rsp_err_b, !vt[i].hit);
            tick();
        end

        // Rule 6 moved to port 5 clears the conflict; the following write waits out the scan
        do_write(4'd6, 1'b1, 3'd5, 48'h0000_8000_0000, 48'h0000_8000_1000, st);
        check("rewrite_no_stall", st, 0);
        do_write(4'd9, 1'b1, 3'd7, 48'h2000, 48'h2000, st);
        check("second_write_stall", st, 120);
        check("overlap_cleared", overlap_a, 0);
        check("rescan_busy", scan_busy_a, 1);
        wait_scan(n);
        do_write(4'd10, 1'b0, 3'd6, 48'h1000, 48'h3000, st);
        wait_scan(n);
        check("overlap_still_clear", overlap_a, 0);

        // Empty rule and disabled rule both cover 0x2000: default port
        send_req(48'h2000); req_valid = 1'b0;
        wait_rsp(got);
        check("empty_rule_port", rsp_port_a, 3);
        check("empty_rule_hit", rsp_hit_a, 0);
        tick();

        // Eight back-to-back lookups with a three-cycle consumer stall
        base = n_rsp;
        fork
            begin
                for (int k = 0; k < 8; k++) send_req(stream_addr[k]);
                req_valid = 1'b0;
            end
            begin
                tick(); tick();
                rsp_ready = 1'b0;
                tick(); tick(); tick();
                rsp_ready = 1'b1;
            end
        join
        n = 0;
        while (n_rsp < base + 8 && n < 50) begin tick(); n++; end
        check("stream_count", n_rsp - base, 8);

        // Same-cycle write and lookup: first lookup sees the old table, the next one the new rule
        base = log_port.size();
        cfg_valid = 1'b1; cfg_idx = 4'd0; cfg_en = 1'b1; cfg_port = 3'd4;
        cfg_start = 48'h4000; cfg_end = 48'h6000;
        req_valid = 1'b1; req_addr = 48'h5000;
        @(negedge clk);
        check("same_cycle_cfg_ready", cfg_ready_a, 1);
        check("same_cycle_req_ready", req_ready_a, 1);
        tick();
        cfg_valid = 1'b0;
        tick();
        req_valid = 1'b0;
        n = 0;
        while (log_port.size() < base + 2 && n < 20) begin tick(); n++; end
        check("same_cycle_rsp_count", log_port.size() - base, 2);
        if (log_port.size() >= base + 2) begin
            check("old_mapping_port", log_port[base], 3);
            check("old_mapping_hit", log_hit[base], 0);
            check("new_mapping_port", log_port[base+1], 4);
            check("new_mapping_hit", log_hit[base+1], 1);
        end
        wait_scan(n);

        // Rule 3 (port 2) overlaps rule 0 (port 4)
        do_write(4'd3, 1'b1, 3'd2, 48'h0, 48'h10000, st);
        wait_scan(n);
        check("overlap_rule3", overlap_a, 1);

        // Reset mid-scan with a lookup in flight
        do_write(4'd4, 1'b1, 3'd2, 48'h20000, 48'h30000, st);
        tick(); tick(); tick();
        send_req(48'h5000); req_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_scan_busy", scan_busy_a, 0);
        check("midrst_cfg_ready", cfg_ready_a, 1);
        check("midrst_overlap", overlap_a, 0);
        check("midrst_rsp_valid", rsp_valid_a, 0);
        tick(); tick();
        check("midrst_dropped", rsp_valid_a, 0);
        send_req(48'h5000); req_valid = 1'b0;
        wait_rsp(got);
        check("midrst_table_cleared", rsp_port_a, 3);
        check("midrst_hit", rsp_hit_a, 0);
        tick();

        // Randomised writes and lookups against the model
        for (int round = 0; round < 3; round++) begin
            done_b = 1'b0;
            fork
                begin
                    for (int w = 0; w < 10; w++) begin
                        logic [AW-1:0] s, e;
                        s = AW'($urandom_range(0, 64)) << 8;
                        e = s + AW'($urandom_range(0, 'h1800));
                        if ($urandom % 8 == 0) e = s >> 1;
                        do_write(RW'($urandom % NR), ($urandom % 4) != 0,
                                 (round == 2) ? 3'd6 : IW'($urandom % NP), s, e, st);
                    end
                end
                begin
                    for (int k = 0; k < 150; k++) begin
                        if ($urandom % 3 == 0) begin req_valid = 1'b0; tick(); end
                        if ($urandom % 10 == 0) begin
                            tmp64 = {$urandom(), $urandom()};
                            send_req(tmp64[AW-1:0]);
                        end else begin
                            send_req(AW'($urandom_range(0, 'h5800)));
                        end
                    end
                    req_valid = 1'b0;
                    done_b = 1'b1;
                end
                begin
                    while (!done_b) begin
                        rsp_ready = ($urandom % 4) != 0;
                        tick();
                    end
                    rsp_ready = 1'b1;
                end
            join
            n = 0;
            while (sb.size() != 0 && n < 100) begin tick(); n++; end
            check("rand_drain", sb.size(), 0);
            wait_scan(n);
            check("rand_overlap", overlap_a, ref_overlap());
            check("rand_overlap_nd", overlap_b, ref_overlap());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
